flag_status_unit: RTL and testbench

Registered, parametrised status-flag unit for the pipeline's execute/writeback boundary. It derives zero, sign, carry and overflow (Z, S, C, V) from the ALU result and operands for any data width, and holds them in a one-entry pending stage. It commits them into the architectural flag register under stall, flush, per-flag write mask and direct-load control. It also provides a forwarded flag view for dependent branches, plus a sticky overflow bit and a saturating overflow event counter.

---
 rtl/flag_status_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_flag_status_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_status_unit.sv
// ============================================================================
// flag_status_unit
//
// Status-flag unit at the execute/writeback boundary. Derives Z, S, C and V
// from the ALU result and operands, parks them in a one-entry pending stage,
// and commits them into the architectural flag register under stall, flush,
// per-flag write mask and direct-load control. Also provides a forwarded flag
// view for dependent branches, a sticky overflow bit and a saturating
// overflow event counter.
//
// Flag vectors are ordered {Z, S, C, V} (bit 3 .. bit 0).
//
// Parameters
//   WIDTH  datapath width in bits (>= 2)
//   OPW    ALU operation code width (>= 4)
//   CNTW   overflow event counter width
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   valid_in        ALU result on the inputs is valid this cycle
//   alu_op          ALU operation code
//   alu_result      ALU result
//   op_a            first operand
//   op_b            second operand / shift amount for shift ops
//   carry_in        adder carry-out from the ALU
//   flag_we         per-flag write mask {Z,S,C,V}, sampled with valid_in
//   stall           hold pending stage, block commit
//   flush           discard pending stage (and drop a same-cycle valid_in)
//   flags_load      direct write of architectural flags
//   flags_load_val  value for flags_load
//   sticky_clr      clear sticky_v and ovf_count
//   flags           architectural flags (registered)
//   flags_fwd       pending entry merged over architectural flags (comb)
//   pending         pending stage holds a valid entry
//   sticky_v        set by any committed V=1
//   ovf_count       saturating count of committed V=1
// ============================================================================
module flag_status_unit #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    input  logic [3:0]       flag_we,
    input  logic             stall,
    input  logic             flush,
    input  logic             flags_load,
    input  logic [3:0]       flags_load_val,
    input  logic             sticky_clr,
    output logic [3:0]       flags,
    output logic [3:0]       flags_fwd,
    output logic             pending,
    output logic             sticky_v,
    output logic [CNTW-1:0]  ovf_count
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [OPW-1:0] {
        OP_ADD = OPW'(0),
        OP_SUB = OPW'(1),
        OP_AND = OPW'(2),
        OP_OR  = OPW'(3),
        OP_XOR = OPW'(4),
        OP_MOV = OPW'(5),
        OP_ADC = OPW'(6),
        OP_SHL = OPW'(7),
        OP_SHR = OPW'(8),
        OP_ASR = OPW'(9),
        OP_ROR = OPW'(10),
        OP_ROL = OPW'(11),
        OP_ZS  = OPW'(12)
    } alu_op_e;

    // ------------------------------------------------------------------
    // Raw flag derivation
    // ------------------------------------------------------------------
    logic             raw_z;
    logic             raw_s;
    logic             raw_c;
    logic             raw_v;
    logic [3:0]       force_mask;
    logic [3:0]       raw_flags;
    logic [3:0]       eff_mask;

    logic             add_ovf;
    logic             sub_ovf;
    logic             shift_ovf;

    logic             shamt_zero;
    logic             shamt_ok;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;

    assign raw_z = (alu_result == '0);
    assign raw_s = alu_result[MSB];

    assign add_ovf   = (op_a[MSB] == op_b[MSB]) & (alu_result[MSB] != op_a[MSB]);
    assign sub_ovf   = (op_a[MSB] != op_b[MSB]) & (alu_result[MSB] != op_a[MSB]);
    assign shift_ovf = (op_a[MSB] != alu_result[MSB]);

    // Shift carry is the last bit shifted out. Rather than a variable bit
    // select, the operand is shifted so the wanted bit lands in bit 0:
    // right shifts want a[s-1], left shifts want a[WIDTH-s]. Both shift
    // amounts are only meaningful for 1 <= s <= WIDTH, which shamt_ok gates.
    assign shamt_zero = (op_b == '0);
    assign shamt_ok   = !shamt_zero && ({1'b0, op_b} <= (WIDTH+1)'(WIDTH));
    assign shr_vec    = op_a >> (op_b - WIDTH'(1));
    assign shl_vec    = op_a >> (WIDTH'(WIDTH) - op_b);

    always_comb begin
        raw_c      = 1'b0;
        raw_v      = 1'b0;
        force_mask = 4'b0000;
        case (alu_op)
            OP_ADD, OP_ADC: begin
                raw_c      = carry_in;
                raw_v      = add_ovf;
                force_mask = 4'b1111;
            end
            OP_SUB: begin
                raw_c      = carry_in;
                raw_v      = sub_ovf;
                force_mask = 4'b1111;
            end
            OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                force_mask = 4'b1111;
            end
            OP_SHL, OP_ROL: begin
                raw_c      = shamt_ok & shl_vec[0];
                raw_v      = shift_ovf;
                force_mask = {2'b11, !shamt_zero, 1'b1};
            end
            OP_SHR, OP_ASR, OP_ROR: begin
                raw_c      = shamt_ok & shr_vec[0];
                raw_v      = shift_ovf;
                force_mask = {2'b11, !shamt_zero, 1'b1};
            end
            OP_ZS: begin
                force_mask = 4'b1100;
            end
            default: begin
                force_mask = 4'b0000;
            end
        endcase
    end

    assign raw_flags = {raw_z, raw_s, raw_c, raw_v};
    assign eff_mask  = flag_we & force_mask;

    // ------------------------------------------------------------------
    // Pending stage
    // ------------------------------------------------------------------
    logic       pend_valid;
    logic [3:0] pend_flags;
    logic [3:0] pend_mask;
    logic       commit;
    logic       ovf_event;

    assign commit    = pend_valid & ~stall & ~flush;
    // A direct load consumes the pending entry without any of its side effects.
    assign ovf_event = commit & ~flags_load & pend_mask[0] & pend_flags[0];

    // Flush outranks stall; without stall the stage either refills from
    // valid_in or empties after its commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_flags <= '0;
            pend_mask  <= '0;
        end else if (flush) begin
            pend_valid <= 1'b0;
        end else if (!stall) begin
            pend_valid <= valid_in;
            if (valid_in) begin
                pend_flags <= raw_flags;
                pend_mask  <= eff_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Architectural flags
    // ------------------------------------------------------------------
    logic [3:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (flags_load) begin
            flags_q <= flags_load_val;
        end else if (commit) begin
            flags_q <= (flags_q & ~pend_mask) | (pend_flags & pend_mask);
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow and saturating event counter
    // ------------------------------------------------------------------
    logic            sticky_q;
    logic [CNTW-1:0] cnt_q;

    // A new overflow on the same edge as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (ovf_event) begin
            sticky_q <= 1'b1;
            if (sticky_clr) begin
                cnt_q <= CNTW'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end else if (sticky_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [3:0] fwd_sel;

    assign fwd_sel   = pend_valid ? pend_mask : 4'b0000;
    assign flags_fwd = (pend_flags & fwd_sel) | (flags_q & ~fwd_sel);
    assign flags     = flags_q;
    assign pending   = pend_valid;
    assign sticky_v  = sticky_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_flag_status_unit.sv
module tb_flag_status_unit;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       carry_in;
    logic [3:0] flag_we;
    logic       stall;
    logic       flush;
    logic       flags_load;
    logic [3:0] flags_load_val;
    logic       sticky_clr;

    logic [3:0] flags8, fwd8, flags2, fwd2;
    logic       pend8, pend2, sticky8, sticky2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    flag_status_unit #(.WIDTH(8), .OPW(4), .CNTW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op(alu_op),
        .alu_result(alu_result), .op_a(op_a), .op_b(op_b), .carry_in(carry_in),
        .flag_we(flag_we), .stall(stall), .flush(flush), .flags_load(flags_load),
        .flags_load_val(flags_load_val), .sticky_clr(sticky_clr),
        .flags(flags8), .flags_fwd(fwd8), .pending(pend8),
        .sticky_v(sticky8), .ovf_count(cnt8)
    );

    flag_status_unit #(.WIDTH(8), .OPW(4), .CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_op(alu_op),
        .alu_result(alu_result), .op_a(op_a), .op_b(op_b), .carry_in(carry_in),
        .flag_we(flag_we), .stall(stall), .flush(flush), .flags_load(flags_load),
        .flags_load_val(flags_load_val), .sticky_clr(sticky_clr),
        .flags(flags2), .flags_fwd(fwd2), .pending(pend2),
        .sticky_v(sticky2), .ovf_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] fwd;
        logic       pend;
        logic       sticky;
        logic [7:0] c8;
        logic [1:0] c2;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Monitor: after every rising edge, pop the expectation queued for it.
    always @(posedge clk) begin
        exp_t e;
        logic bad;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bad = 1'b0;
            vectors++;
            if (flags8 !== e.flags || flags2 !== e.flags) begin
                $display("FAIL %s flags: got %b/%b expected %b", e.name, flags8, flags2, e.flags);
                bad = 1'b1;
            end
            if (fwd8 !== e.fwd || fwd2 !== e.fwd) begin
                $display("FAIL %s flags_fwd: got %b/%b expected %b", e.name, fwd8, fwd2, e.fwd);
                bad = 1'b1;
            end
            if (pend8 !== e.pend || pend2 !== e.pend) begin
                $display("FAIL %s pending: got %b/%b expected %b", e.name, pend8, pend2, e.pend);
                bad = 1'b1;
            end
            if (sticky8 !== e.sticky || sticky2 !== e.sticky) begin
                $display("FAIL %s sticky_v: got %b/%b expected %b", e.name, sticky8, sticky2, e.sticky);
                bad = 1'b1;
            end
            if (cnt8 !== e.c8) begin
                $display("FAIL %s ovf_count(CNTW=8): got %0d expected %0d", e.name, cnt8, e.c8);
                bad = 1'b1;
            end
            if (cnt2 !== e.c2) begin
                $display("FAIL %s ovf_count(CNTW=2): got %0d expected %0d", e.name, cnt2, e.c2);
                bad = 1'b1;
            end
            if (bad) miscompares++;
        end
    end

    task automatic clr();
        valid_in = 1'b0; alu_op = 4'd0; alu_result = 8'h00; op_a = 8'h00; op_b = 8'h00;
        carry_in = 1'b0; flag_we = 4'b1111; stall = 1'b0; flush = 1'b0;
        flags_load = 1'b0; flags_load_val = 4'b0000; sticky_clr = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic cin);
        valid_in = 1'b1; alu_op = op; op_a = a; op_b = b; alu_result = r; carry_in = cin;
    endtask

    // Queue the expected state after the coming rising edge, then advance.
    task automatic step(input logic [3:0] ef, input logic [3:0] efwd, input logic ep,
                        input logic est, input logic [7:0] c8, input logic [1:0] c2,
                        input string nm);
        exp_t e;
        e.flags = ef; e.fwd = efwd; e.pend = ep; e.sticky = est;
        e.c8 = c8; e.c2 = c2; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        step(4'b0000, 4'b0000, 0, 0, 0, 0, "reset0");
        step(4'b0000, 4'b0000, 0, 0, 0, 0, "reset1");
        rst_n = 1'b1;

        // ADD overflow, latency 2
        clr(); alu(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0);
        step(4'b0000, 4'b0101, 1, 0, 0, 0, "add_cap");
        clr();
        step(4'b0101, 4'b0101, 0, 1, 1, 1, "add_commit");

        // SHL s=1 then SHL s=0 back-to-back
        clr(); alu(4'd7, 8'h81, 8'h01, 8'h02, 1'b0);
        step(4'b0101, 4'b0011, 1, 1, 1, 1, "shl1_cap");
        clr(); alu(4'd7, 8'h80, 8'h00, 8'h80, 1'b0);
        step(4'b0011, 4'b0110, 1, 1, 2, 2, "shl1_commit");
        clr();
        step(4'b0110, 4'b0110, 0, 1, 2, 2, "shl0_commit");

        // SUB zero result held by stall (inputs during stall are ignored)
        clr(); alu(4'd1, 8'h05, 8'h05, 8'h00, 1'b1);
        step(4'b0110, 4'b1010, 1, 1, 2, 2, "sub_cap");
        for (int i = 0; i < 3; i++) begin
            clr(); stall = 1'b1; alu(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0);
            step(4'b0110, 4'b1010, 1, 1, 2, 2, "sub_stall");
        end
        clr();
        step(4'b1010, 4'b1010, 0, 1, 2, 2, "sub_commit");

        // flush + stall together discards the pending entry and new input
        clr(); alu(4'd0, 8'h7F, 8'h7F, 8'hFE, 1'b0);
        step(4'b1010, 4'b0101, 1, 1, 2, 2, "flush_cap");
        clr(); stall = 1'b1; flush = 1'b1; alu(4'd0, 8'h7F, 8'h7F, 8'hFE, 1'b0);
        step(4'b1010, 4'b1010, 0, 1, 2, 2, "flush_stall");
        clr();
        step(4'b1010, 4'b1010, 0, 1, 2, 2, "flush_after");

        // flags_load beats a V=1 commit
        clr(); alu(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0);
        step(4'b1010, 4'b0101, 1, 1, 2, 2, "load_cap");
        clr(); flags_load = 1'b1; flags_load_val = 4'b1010;
        step(4'b1010, 4'b1010, 0, 1, 2, 2, "load_vs_commit");
        clr(); flags_load = 1'b1; flags_load_val = 4'b0100;
        step(4'b0100, 4'b0100, 0, 1, 2, 2, "load_plain");

        // sticky_clr alone
        clr(); sticky_clr = 1'b1;
        step(4'b0100, 4'b0100, 0, 0, 0, 0, "sticky_clr");

        // Five overflowing ADDs back-to-back; CNTW=2 saturates at 3
        clr(); alu(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0);
        step(4'b0100, 4'b0101, 1, 0, 0, 0, "ovf_cap1");
        step(4'b0101, 4'b0101, 1, 1, 1, 1, "ovf_c1");
        step(4'b0101, 4'b0101, 1, 1, 2, 2, "ovf_c2");
        step(4'b0101, 4'b0101, 1, 1, 3, 3, "ovf_c3");
        step(4'b0101, 4'b0101, 1, 1, 4, 3, "ovf_c4");
        clr();
        step(4'b0101, 4'b0101, 0, 1, 5, 3, "ovf_c5");

        // sticky_clr on the same edge as a V commit
        clr(); alu(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0);
        step(4'b0101, 4'b0101, 1, 1, 5, 3, "clr_v_cap");
        clr(); sticky_clr = 1'b1;
        step(4'b0101, 4'b0101, 0, 1, 1, 1, "clr_v_commit");

        // Op 12: Z/S only
        clr(); alu(4'd12, 8'hFF, 8'h01, 8'h00, 1'b1);
        step(4'b0101, 4'b1001, 1, 1, 1, 1, "op12_cap");
        clr();
        step(4'b1001, 4'b1001, 0, 1, 1, 1, "op12_commit");
        // Op 13: accepted, no update
        clr(); alu(4'd13, 8'h00, 8'h00, 8'h00, 1'b1);
        step(4'b1001, 4'b1001, 1, 1, 1, 1, "op13_cap");
        clr();
        step(4'b1001, 4'b1001, 0, 1, 1, 1, "op13_commit");
        // XOR clears C and V
        clr(); alu(4'd4, 8'hFF, 8'h0F, 8'hF0, 1'b1);
        step(4'b1001, 4'b0100, 1, 1, 1, 1, "xor_cap");
        clr();
        step(4'b0100, 4'b0100, 0, 1, 1, 1, "xor_commit");
        // ROR s=1: C=a[0], V from MSB change
        clr(); alu(4'd10, 8'h01, 8'h01, 8'h80, 1'b0);
        step(4'b0100, 4'b0111, 1, 1, 1, 1, "ror_cap");
        clr();
        step(4'b0111, 4'b0111, 0, 1, 2, 2, "ror_commit");
        // AND with write mask Z only
        clr(); alu(4'd2, 8'hF0, 8'h0F, 8'h00, 1'b0); flag_we = 4'b1000;
        step(4'b0111, 4'b1111, 1, 1, 2, 2, "mask_cap");
        clr();
        step(4'b1111, 4'b1111, 0, 1, 2, 2, "mask_commit");
        // SHL s=WIDTH: C=a[0]
        clr(); alu(4'd7, 8'h01, 8'h08, 8'h00, 1'b0);
        step(4'b1111, 4'b1010, 1, 1, 2, 2, "shl8_cap");
        clr();
        step(4'b1010, 4'b1010, 0, 1, 2, 2, "shl8_commit");
        // SHR s=WIDTH+1: C=0
        clr(); alu(4'd8, 8'hFF, 8'h09, 8'h00, 1'b0);
        step(4'b1010, 4'b1001, 1, 1, 2, 2, "shr9_cap");
        clr();
        step(4'b1001, 4'b1001, 0, 1, 3, 3, "shr9_commit");
        // SHR s=1: C=a[0]
        clr(); alu(4'd8, 8'h03, 8'h01, 8'h01, 1'b0);
        step(4'b1001, 4'b0010, 1, 1, 3, 3, "shr1_cap");
        clr();
        step(4'b0010, 4'b0010, 0, 1, 3, 3, "shr1_commit");

        // Reset mid-operation discards the pending entry
        clr(); alu(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0);
        step(4'b0010, 4'b0101, 1, 1, 3, 3, "rst_cap");
        clr(); rst_n = 1'b0;
        step(4'b0000, 4'b0000, 0, 0, 0, 0, "rst_mid");
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, 0, 0, 0, 0, "rst_after");

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d queued expectations expected 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
